// File: rtl/reduce_seq_unit.sv
// Multi-cycle OR/AND/XOR/NOR reducer: folds CHUNK operand bits per cycle under valid/ready handshakes.
// Optional macro REDUCE_EARLY_EXIT_EN finishes as soon as the dominant value is reached.
module reduce_seq_unit #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inp,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned NUM_STEPS = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int unsigned STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int unsigned PAD_W     = NUM_STEPS * CHUNK;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [STEP_W-1:0]  step_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [1:0]         mode_q;
    logic               acc_q;

    logic               accept;
    logic [PAD_W-1:0]   padded;
    logic [CHUNK-1:0]   chunk;
    logic               acc_fold;
`ifdef REDUCE_EARLY_EXIT_EN
    logic               dominant;
`endif

    assign in_ready = (state_q == IDLE) && !rst;

    // Padding bits beyond WIDTH carry the identity of the latched mode.
    always_comb begin
        padded                = {PAD_W{mode_q == 2'b01}};
        padded[WIDTH-1:0]     = opnd_q;
        chunk                 = padded[step_q*CHUNK +: CHUNK];
        case (mode_q)
            2'b01:   acc_fold = acc_q & (&chunk);
            2'b10:   acc_fold = acc_q ^ (^chunk);
            default: acc_fold = acc_q | (|chunk);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
`ifdef REDUCE_EARLY_EXIT_EN
        dominant = (mode_q == 2'b01) ? !acc_fold : ((mode_q != 2'b10) && acc_fold);
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (step_q == LAST_STEP) begin
                    state_d = DONE;
                end
`ifdef REDUCE_EARLY_EXIT_EN
                if (dominant) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, accumulator, step counter and registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q    <= '0;
            opnd_q    <= '0;
            mode_q    <= 2'b00;
            acc_q     <= 1'b0;
            out       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        opnd_q <= inp;
                        mode_q <= mode;
                        acc_q  <= (mode == 2'b01);
                        step_q <= '0;
                    end
                end
                BUSY: begin
                    acc_q <= acc_fold;
                    if (state_d == DONE) begin
                        out       <= acc_fold ^ (mode_q == 2'b11);
                        out_valid <= 1'b1;
                    end else begin
                        step_q <= step_q + STEP_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_reduce_seq_unit.sv
// Directed bench for reduce_seq_unit: one instance with CHUNK=1 and one with CHUNK=2, both WIDTH=5.
module tb_reduce_seq_unit;

`ifdef REDUCE_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] inp       [2];
    logic [1:0] mode      [2];
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic       out       [2];
    logic       out_valid [2];
    logic       out_ready [2];

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    reduce_seq_unit #(.WIDTH(5), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .inp(inp[0]), .mode(mode[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .out(out[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0])
    );

    reduce_seq_unit #(.WIDTH(5), .CHUNK(2)) u_c2 (
        .clk(clk), .rst(rst), .inp(inp[1]), .mode(mode[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .out(out[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1])
    );

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One transaction: accept, wait for result, optional DONE backpressure, then handshake.
    task automatic run_op(input int d, input logic [4:0] v, input logic [1:0] m, input logic exp,
                          input int lat, input int hold, input bit churn, input string tag);
        int n;
        chk(32'(in_ready[d]), 32'd1, {tag, "_rdy"});
        inp[d]      = v;
        mode[d]     = m;
        in_valid[d] = 1'b1;
        tick();
        in_valid[d] = 1'b0;
        n = 0;
        while (out_valid[d] !== 1'b1 && n < 20) begin
            if (churn) begin
                inp[d]  = 5'($urandom);
                mode[d] = 2'($urandom);
            end
            tick();
            n++;
        end
        chk(32'(n), 32'(lat), {tag, "_lat"});
        chk(32'(out[d]), 32'(exp), {tag, "_out"});
        for (int i = 0; i < hold; i++) begin
            in_valid[d] = 1'b1;
            inp[d]      = ~v;
            tick();
            chk(32'(out_valid[d]), 32'd1, {tag, "_hold_vld"});
            chk(32'(out[d]), 32'(exp), {tag, "_hold_out"});
            chk(32'(in_ready[d]), 32'd0, {tag, "_hold_rdy"});
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        tick();
        out_ready[d] = 1'b0;
        chk(32'(out_valid[d]), 32'd0, {tag, "_drop"});
        chk(32'(in_ready[d]), 32'd1, {tag, "_idle"});
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            inp[d]       = '0;
            mode[d]      = '0;
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
        end
        #2;
        chk(32'(out_valid[0]), 32'd0, "rst_vld0");
        chk(32'(in_ready[0]), 32'd0, "rst_rdy0");
        chk(32'(out_valid[1]), 32'd0, "rst_vld1");
        chk(32'(in_ready[1]), 32'd0, "rst_rdy1");
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk(32'(in_ready[0]), 32'd1, "rel_rdy0");

        // Reset in the middle of BUSY discards the operation.
        inp[0]      = 5'b10000;
        mode[0]     = 2'b00;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk(32'(out_valid[0]), 32'd0, "abort_vld");
        chk(32'(in_ready[0]), 32'd0, "abort_rdy");
        tick();
        rst = 1'b0;
        #1;
        chk(32'(in_ready[0]), 32'd1, "abort_rel_rdy");
        for (int i = 0; i < 6; i++) begin
            tick();
            chk(32'(out_valid[0]), 32'd0, "abort_no_stale");
        end

        // CHUNK=1 sweep
        run_op(0, 5'b00000, 2'b00, 1'b0, 5,           0, 1'b0, "or_00000");
        run_op(0, 5'b00001, 2'b00, 1'b1, EE ? 1 : 5,  0, 1'b0, "or_00001");
        run_op(0, 5'b00100, 2'b00, 1'b1, EE ? 3 : 5,  0, 1'b0, "or_00100");
        run_op(0, 5'b10000, 2'b00, 1'b1, 5,           0, 1'b0, "or_10000");
        run_op(0, 5'b00001, 2'b10, 1'b1, 5,           0, 1'b0, "xor_00001");
        run_op(0, 5'b00000, 2'b11, 1'b1, 5,           0, 1'b0, "nor_00000");
        run_op(0, 5'b00100, 2'b11, 1'b0, EE ? 3 : 5,  0, 1'b0, "nor_00100");

        // CHUNK=2: three steps, last chunk padded
        run_op(1, 5'b11111, 2'b01, 1'b1, 3,           0, 1'b0, "and_11111");
        run_op(1, 5'b11011, 2'b01, 1'b0, EE ? 2 : 3,  0, 1'b0, "and_11011");
        run_op(1, 5'b10110, 2'b10, 1'b1, 3,           0, 1'b0, "xor_10110");
        run_op(1, 5'b00000, 2'b11, 1'b1, 3,           0, 1'b0, "nor_c2_00000");

        // Backpressure in DONE and input churn during BUSY
        run_op(0, 5'b00001, 2'b00, 1'b1, EE ? 1 : 5, 10, 1'b0, "bp_or");
        run_op(1, 5'b11011, 2'b01, 1'b0, EE ? 2 : 3,  0, 1'b1, "churn_and");
        run_op(0, 5'b10110, 2'b10, 1'b1, 5,           0, 1'b1, "churn_xor");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
